// File: rtl/punc_pkg.sv
// Shared definitions for the PUnC memory responder: FSM encodings, word width
// and wait-state counter sizing.
package punc_pkg;

    localparam int PUNC_DATA_W     = 16;
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    // Addresses are widened to 32 bits so one compare works for any ADDR_W.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/punc_word_ram.sv
// Word array for the responder: combinational read, one synchronous write port
// shared by the request path and the side-band loader (loader wins).
module punc_word_ram
    import punc_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = PUNC_DATA_W
) (
    input  logic              clk,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_waddr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Out-of-range writes are dropped here so they never alias onto low words.
    always_comb begin
        we    = 1'b0;
        waddr = req_waddr;
        wdata = req_wdata;
        if (ld_we) begin
            we    = addr_in_range(32'(ld_waddr), DEPTH);
            waddr = ld_waddr;
            wdata = ld_wdata;
        end else if (req_we) begin
            we    = addr_in_range(32'(req_waddr), DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = addr_in_range(32'(raddr), DEPTH) ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/punc_mem_responder.sv
// Memory-side responder for the PUnC LC3 core: valid/ready request channel,
// fixed wait states, one-cycle response pulse, and a side-band preload port.
module punc_mem_responder
    import punc_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = PUNC_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  accept;
    logic                  req_in_range;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     accept_rdata;
    logic [DATA_W-1:0]     cap_rdata;
    logic                  cap_err;

    assign req_ready    = (state == ST_IDLE) && !ld_en;
    assign accept       = req_valid && req_ready;
    assign req_in_range = addr_in_range(32'(req_addr), DEPTH);
    assign accept_rdata = (req_write || !req_in_range) ? '0 : ram_rdata;
    assign rsp_valid    = (state == ST_RESPOND);
    assign busy         = (state != ST_IDLE);

    punc_word_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .req_we    (accept && req_write),
        .req_waddr (req_addr),
        .req_wdata (req_wdata),
        .ld_we     (ld_en),
        .ld_waddr  (ld_addr),
        .ld_wdata  (ld_data),
        .raddr     (req_addr),
        .rdata     (ram_rdata)
    );

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESPOND;
                end
            end
            ST_WAIT:    state_nxt = (wait_cnt == '0) ? ST_RESPOND : ST_WAIT;
            ST_RESPOND: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // The accept-edge capture isolates the result from later loader writes;
    // the visible outputs only change when a response is actually presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rdata <= '0;
            cap_err   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_rdata <= accept_rdata;
                cap_err   <= !req_in_range;
            end
            if (state_nxt == ST_RESPOND) begin
                rsp_rdata <= (state == ST_IDLE) ? accept_rdata : cap_rdata;
                rsp_err   <= (state == ST_IDLE) ? !req_in_range : cap_err;
            end
        end
    end

endmodule

// File: doc/punc_mem_responder.md
# punc_mem_responder

Memory-side responder for the PUnC LC3 core. It accepts word read/write requests issued by the core's control/datapath over a valid/ready request channel, stalls for a fixed number of wait states, and returns a one-cycle response pulse with read data and an error flag. A side-band loader port preloads program/data words, for example while the core sits in its halt state, so the block is the memory end of the core's load/store traffic.

## Interface
Parameters:
- DEPTH, 256, number of 16-bit words implemented (1..65536)
- ADDR_W, 16, request/loader address width
- DATA_W, 16, word width
- WAIT_CYCLES, 1, wait states between accept and response (0..15)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response/acknowledge pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address >= DEPTH, valid with rsp_valid
- ld_en  in  1  loader write strobe
- ld_addr  in  ADDR_W  loader address
- ld_data  in  DATA_W  loader data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - req_ready = !ld_en.
  - On req_valid & req_ready, the request is accepted and the next state is WAIT if WAIT_CYCLES > 0, else RESPOND.
- Accept edge:
  - A write commits to the array at this edge.
  - A read samples array[req_addr] into the response register at this edge.
  - req_addr >= DEPTH sets the error register. The write is dropped and read data is 0.
- WAIT:
  - The counter loads WAIT_CYCLES-1 on accept and decrements each cycle.
  - At 0 the next state is RESPOND.
  - req_ready = 0.
- RESPOND:
  - rsp_valid = 1 for exactly this cycle.
  - rsp_rdata and rsp_err are driven from registers.
  - Next state is IDLE. req_ready = 0.
- Loader:
  - ld_en writes ld_data to array[ld_addr] on any cycle, in any state.
  - ld_addr >= DEPTH is ignored silently.
  - In IDLE, the loader has priority because req_ready drops combinationally.
  - A loader write to an address with a read in flight does not alter the already-captured rsp_rdata.
- rsp_rdata holds its last value until the next RESPOND. It reads 0 after reset.
- Array contents are not cleared by reset.

## Timing
- Reset values: req_ready=1 (if ld_en=0), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE, counter=0.
- Latency: accept in cycle T gives rsp_valid in cycle T+1+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles. The next accept is possible in the cycle after RESPOND.
- Read-after-write to the same address, issued as back-to-back requests, returns the new data.
- Read with a same-cycle loader write to the same address: the request is not accepted that cycle. The read is accepted later and returns the loader data.
- The requester must hold req_* stable while req_valid=1 and req_ready=0. The responder samples only on the accept edge.
- Reset asserted mid-transaction:
  - FSM returns to IDLE immediately and the pending response is discarded; no rsp_valid.
  - A write already committed at its accept edge remains in the array.

## Structure
- Shared package (punc_pkg / Defines): FSM state encodings (2-bit), the DATA_W word-width constant, and the maximum WAIT_CYCLES constant (15, 4-bit counter).
- One sub-module: punc_word_ram.
  - Combinational read, synchronous write.
  - One write port muxed between request and loader, with the loader winning.
  - One read port.
- The FSM, counter, and response registers live in the top.

## Test plan
- Reset: rst_n=0 mid-WAIT → rsp_valid=0, busy=0, rsp_rdata=0 immediately. No response pulse after release.
- Loader preload: ld_en writes 0x1234 @ 0x0010 with WAIT_CYCLES=1. A read of 0x0010 accepted at T → rsp_valid only at T+2, rdata=0x1234, err=0.
- Write then read: write 0xBEEF @ 0x0005, then a read of 0x0005 accepted the cycle after RESPOND → rdata=0xBEEF. The write response has rdata=0 and err=0.
- Out of range (DEPTH=256): write 0xAAAA @ 0x0100 → rsp_err=1. A following read of 0x0000 is unchanged, and a read of 0x0100 → rdata=0, err=1.
- Loader priority: ld_en=1 and req_valid=1 in IDLE → req_ready=0 that cycle, request accepted next cycle. A loader write to an in-flight read address does not change rsp_rdata.
- WAIT_CYCLES=0 and 15: response at T+1 and T+16 respectively. busy is high from T+1 until the RESPOND cycle inclusive.
